mem_read_credit_buffer: RTL and testbench

// - Sits between the role's request/response logic and the DRAM interleaver.
// - Forwards MemReq downstream. Issues a read only when a response slot is already reserved in a local FIFO.
// - Because of that reservation, mem_resp_grant_out never has to stall the interleaver.
// - Decouples the consumer side (pcie_grant_in backpressure) from DRAM, and provides a drain/flush handshake plus stats.

---
 rtl/mem_read_credit_buffer.sv | 196 +++++++++++++++++++
 tb/tb_mem_read_credit_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_credit_buffer.sv
// Read-credit buffer between request/response logic and the DRAM interleaver; reads issue only with a reserved response slot.
// Latency: request path combinational; response 1 cycle through a show-ahead FIFO.
// Backpressure: upstream requests held when no credit or draining; interleaver responses never stalled.

package mem_read_credit_buffer_pkg;
    typedef struct packed {
        logic         valid;
        logic         is_write;
        logic [63:0]  addr;
        logic [511:0] data;
    } mem_req_t;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } mem_resp_t;
endpackage

// Generic show-ahead FIFO, 2**LOG_DEPTH entries.
// Latency: 1 cycle push to head; pop and push may coincide, including when full.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module credit_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_dat,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_dat,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 2 ** LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count == '0);
    assign full     = count[LOG_DEPTH];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module mem_read_credit_buffer
    import mem_read_credit_buffer_pkg::*;
#(
    parameter int LOG_DEPTH       = 6,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  mem_req_t           mem_req_in,
    output logic               mem_req_grant_out,
    output mem_resp_t          mem_resp_out,
    input  logic               mem_resp_grant_in,
    output mem_req_t           mem_req_out,
    input  logic               mem_req_grant_in,
    input  mem_resp_t          mem_resp_in,
    output logic               mem_resp_grant_out,
    input  logic               flush_req,
    output logic               flush_done,
    output logic [LOG_DEPTH:0] outstanding,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count,
    output logic               resp_err
);
    localparam logic [LOG_DEPTH:0] DEPTH_L = (LOG_DEPTH + 1)'(2 ** LOG_DEPTH);
    localparam logic [LOG_DEPTH:0] MAX_L   = (LOG_DEPTH + 1)'(MAX_OUTSTANDING);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LOG_DEPTH:0] fifo_count;
    logic [LOG_DEPTH:0] reserved;
    logic               fifo_empty;
    logic               fifo_full;
    logic               read_ok;
    logic               write_ok;
    logic               allowed;
    logic               req_fire;
    logic               rd_fire;
    logic               wr_fire;
    logic               resp_fire;
    logic               deq;
    logic               drained;

    // Slots already promised to in-flight reads count against FIFO space.
    assign reserved = outstanding + fifo_count;
    assign read_ok  = (state == RUN) && (reserved < DEPTH_L) && (outstanding < MAX_L);
    assign write_ok = (state == RUN);
    assign allowed  = !rst && (mem_req_in.is_write ? write_ok : read_ok);

    always_comb begin
        mem_req_out       = mem_req_in;
        mem_req_out.valid = mem_req_in.valid && allowed;
    end

    assign req_fire          = mem_req_out.valid && mem_req_grant_in;
    assign rd_fire           = req_fire && !mem_req_in.is_write;
    assign wr_fire           = req_fire && mem_req_in.is_write;
    assign mem_req_grant_out = req_fire;

    assign resp_fire          = mem_resp_in.valid && !fifo_full;
    assign mem_resp_grant_out = resp_fire;
    assign mem_resp_out.valid = !fifo_empty;
    assign deq                = !fifo_empty && mem_resp_grant_in;

    credit_fifo #(
        .WIDTH     (512),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (resp_fire),
        .push_dat (mem_resp_in.data),
        .pop      (deq),
        .head_dat (mem_resp_out.data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (rd_fire && !resp_fire)
                outstanding <= outstanding + 1'b1;
            else if (resp_fire && !rd_fire && (outstanding != '0))
                outstanding <= outstanding - 1'b1;
            // A response with nothing in flight is a stray (e.g. after reset); keep it but flag it.
            if (resp_fire && (outstanding == '0))
                resp_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_fire) rd_count <= rd_count + 1'b1;
            if (wr_fire) wr_count <= wr_count + 1'b1;
        end
    end

    assign drained = (outstanding == '0) && fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (drained)   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        flush_done = 1'b0;
        if (state == DRAIN) flush_done = drained;
    end
endmodule

// File: tb/tb_mem_read_credit_buffer.sv
// Randomized bench for mem_read_credit_buffer with queue-based reference model and interleaver model.
module tb_mem_read_credit_buffer;
    import mem_read_credit_buffer_pkg::*;

    localparam int LD    = 2;
    localparam int DEPTH = 4;
    localparam int MAXO  = 3;

    logic        clk = 1'b0;
    logic        rst;
    mem_req_t    mem_req_in;
    mem_req_t    mem_req_out;
    mem_resp_t   mem_resp_in;
    mem_resp_t   mem_resp_out;
    logic        mem_req_grant_out;
    logic        mem_req_grant_in;
    logic        mem_resp_grant_in;
    logic        mem_resp_grant_out;
    logic        flush_req;
    logic        flush_done;
    logic [LD:0] outstanding;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        resp_err;

    always #5 clk = ~clk;

    mem_read_credit_buffer #(.LOG_DEPTH(LD), .MAX_OUTSTANDING(MAXO)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_req_in         (mem_req_in),
        .mem_req_grant_out  (mem_req_grant_out),
        .mem_resp_out       (mem_resp_out),
        .mem_resp_grant_in  (mem_resp_grant_in),
        .mem_req_out        (mem_req_out),
        .mem_req_grant_in   (mem_req_grant_in),
        .mem_resp_in        (mem_resp_in),
        .mem_resp_grant_out (mem_resp_grant_out),
        .flush_req          (flush_req),
        .flush_done         (flush_done),
        .outstanding        (outstanding),
        .rd_count           (rd_count),
        .wr_count           (wr_count),
        .resp_err           (resp_err)
    );

    typedef struct { int due; logic [511:0] d; } pend_t;
    typedef struct { bit w; logic [63:0] a; logic [511:0] d; } rq_t;

    int passed = 0, fails = 0, total = 0, cyc_n = 0;
    pend_t        lat_q[$];
    logic [511:0] mf[$];
    rq_t          req_q[$];
    int out_m = 0, rd_m = 0, wr_m = 0;
    bit err_m = 0, drain_m = 0;
    int lat_min = 1, lat_max = 1, req_gnt_pct = 100, resp_gnt_pct = 100;
    bit flush_now = 0, inject_now = 0;
    logic [511:0] inject_d;
    int acc_first, vld_first, peak, rd_gnts, nth_gnt_cyc, last_deq, done_cnt, done_cyc, ing_stall, drain_gnts;

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        total += 1;
        assert (obs === exp) passed += 1;
        else begin
            fails += 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_obs();
        acc_first = -1; vld_first = -1; peak = 0; rd_gnts = 0; nth_gnt_cyc = -1;
        last_deq = -1; done_cnt = 0; done_cyc = -1; ing_stall = 0; drain_gnts = 0;
    endtask

    task automatic add_req(bit w, int n);
        rq_t r;
        for (int i = 0; i < n; i++) begin
            r.w = w; r.a = {$urandom, $urandom}; r.d = rnd512();
            req_q.push_back(r);
        end
    endtask

    task automatic drive();
        mem_req_in = '0;
        if (req_q.size() > 0) begin
            mem_req_in.valid    = 1'b1;
            mem_req_in.is_write = req_q[0].w;
            mem_req_in.addr     = req_q[0].a;
            mem_req_in.data     = req_q[0].d;
        end
        mem_req_grant_in  = (int'($urandom_range(99)) < req_gnt_pct);
        mem_resp_grant_in = (int'($urandom_range(99)) < resp_gnt_pct);
        mem_resp_in = '0;
        if (inject_now) begin
            mem_resp_in.valid = 1'b1;
            mem_resp_in.data  = inject_d;
        end else if (lat_q.size() > 0 && lat_q[0].due <= cyc_n) begin
            mem_resp_in.valid = 1'b1;
            mem_resp_in.data  = lat_q[0].d;
        end
        flush_req = flush_now;
    endtask

    // One cycle: check DUT against the model, then advance the model across the clock edge.
    task automatic cyc();
        bit rd_ok, req_v, req_g, resp_g, deq, fd;
        logic [511:0] resp_d;
        #1;
        rd_ok  = !drain_m && (out_m + mf.size() < DEPTH) && (out_m < MAXO);
        req_v  = (req_q.size() > 0) && (req_q[0].w ? !drain_m : rd_ok);
        req_g  = req_v && mem_req_grant_in;
        resp_g = mem_resp_in.valid && (mf.size() < DEPTH);
        deq    = (mf.size() > 0) && mem_resp_grant_in;
        fd     = drain_m && (out_m == 0) && (mf.size() == 0);
        chk("req_vld", mem_req_out.valid, req_v);
        if (req_v) chk("req_addr", mem_req_out.addr, req_q[0].a);
        chk("req_gnt", mem_req_grant_out, req_g);
        chk("resp_gnt", mem_resp_grant_out, resp_g);
        chk("resp_vld", mem_resp_out.valid, mf.size() > 0);
        if (mf.size() > 0) chk("resp_dat_order", mem_resp_out.data, mf[0]);
        chk("outstanding", outstanding, out_m);
        chk("rd_count", rd_count, rd_m);
        chk("wr_count", wr_count, wr_m);
        chk("resp_err", resp_err, err_m);
        chk("flush_done", flush_done, fd);

        if (mem_resp_grant_out && acc_first < 0) acc_first = cyc_n;
        if (mem_resp_out.valid && vld_first < 0) vld_first = cyc_n;
        if (int'(outstanding) > peak) peak = int'(outstanding);
        if (mem_req_grant_out && !mem_req_in.is_write) begin
            rd_gnts++;
            if (rd_gnts == MAXO + 1) nth_gnt_cyc = cyc_n;
        end
        if (mem_resp_out.valid && mem_resp_grant_in) last_deq = cyc_n;
        if (flush_done) begin done_cnt++; done_cyc = cyc_n; end
        if (mem_resp_in.valid && !mem_resp_grant_out) ing_stall++;
        if (drain_m && mem_req_grant_out) drain_gnts++;

        resp_d = inject_now ? inject_d : (lat_q.size() > 0 ? lat_q[0].d : '0);
        if (deq) void'(mf.pop_front());
        if (resp_g) begin
            mf.push_back(resp_d);
            if (out_m == 0) err_m = 1;
            if (!inject_now) void'(lat_q.pop_front());
        end
        if (req_g) begin
            if (req_q[0].w) wr_m++;
            else begin
                rd_m++;
                lat_q.push_back('{cyc_n + int'($urandom_range(lat_max, lat_min)), req_q[0].d});
            end
            void'(req_q.pop_front());
        end
        if (req_g && !(mem_req_in.is_write) && !resp_g) out_m++;
        else if (resp_g && !(req_g && !mem_req_in.is_write) && out_m > 0) out_m--;
        if (fd) drain_m = 0;
        else if (!drain_m && flush_now) drain_m = 1;
        flush_now  = 0;
        inject_now = 0;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) begin drive(); cyc(); end
    endtask

    task automatic run_until_idle(int budget, string tag);
        int k = 0;
        while ((req_q.size() > 0 || lat_q.size() > 0 || mf.size() > 0) && k < budget) begin
            drive(); cyc(); k++;
        end
        chk(tag, k < budget, 1'b1);
    endtask

    task automatic do_reset(bit keep_inflight);
        rst = 1'b1;
        mem_req_in = '0; mem_resp_in = '0; flush_req = 1'b0;
        mem_req_grant_in = 1'b0; mem_resp_grant_in = 1'b0;
        repeat (2) begin @(negedge clk); cyc_n++; end
        rst = 1'b0;
        mf.delete(); req_q.delete();
        if (!keep_inflight) lat_q.delete();
        out_m = 0; rd_m = 0; wr_m = 0; err_m = 0; drain_m = 0;
    endtask

    initial begin
        int k;
        bit w;
        int nw, nr;
        @(negedge clk);
        do_reset(0);
        clr_obs();
        #1;
        chk("rst_resp_vld", mem_resp_out.valid, 1'b0);
        chk("rst_req_vld", mem_req_out.valid, 1'b0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        @(negedge clk); cyc_n++;

        // Single read, 10-cycle interleaver latency.
        lat_min = 10; lat_max = 10;
        add_req(0, 1);
        run_until_idle(40, "single_timeout");
        chk("single_resp_lat", vld_first - acc_first, 1);
        chk("single_peak", peak, 1);
        chk("single_rd_count", rd_count, 1);
        chk("single_outstanding_end", outstanding, 0);

        // Credit limit with consumer stalled.
        clr_obs();
        lat_min = 2; lat_max = 2; resp_gnt_pct = 0;
        add_req(0, 10);
        run(40);
        chk("depth_grants", rd_gnts, DEPTH);
        drive();
        #1;
        chk("depth_held_vld", mem_req_out.valid, 1'b0);
        cyc();
        chk("depth_no_ingress_stall", ing_stall, 0);
        resp_gnt_pct = 100;
        run_until_idle(100, "depth_drain_timeout");
        chk("depth_rd_count", rd_count, 11);

        // Outstanding cap with long latency.
        clr_obs();
        lat_min = 50; lat_max = 50;
        add_req(0, 5);
        run_until_idle(200, "maxo_timeout");
        chk("maxo_peak", peak, MAXO);
        chk("maxo_next_issue", nth_gnt_cyc - acc_first, 1);

        // Mixed writes and reads, random grants and latency.
        clr_obs();
        lat_min = 1; lat_max = 8; req_gnt_pct = 60; resp_gnt_pct = 70;
        nw = 8; nr = 8;
        for (int i = 0; i < 16; i++) begin
            w = (nr == 0) || (nw > 0 && $urandom_range(1) == 1);
            add_req(w, 1);
            if (w) nw--; else nr--;
        end
        run_until_idle(600, "mixed_timeout");
        chk("mixed_rd_count", rd_count, 24);
        chk("mixed_wr_count", wr_count, 8);

        // Flush with reads in flight while upstream keeps presenting.
        clr_obs();
        lat_min = 20; lat_max = 20; req_gnt_pct = 100; resp_gnt_pct = 100;
        add_req(0, 3);
        run(4);
        add_req(0, 3);
        flush_now = 1;
        k = 0;
        while (done_cnt == 0 && k < 100) begin drive(); cyc(); k++; end
        chk("flush_timeout", k < 100, 1'b1);
        chk("flush_no_grants", drain_gnts, 0);
        chk("flush_done_timing", done_cyc - last_deq, 1);
        chk("flush_held_reads", req_q.size(), 3);
        run_until_idle(150, "flush_resume_timeout");
        chk("flush_resume_rd_count", rd_count, 30);
        chk("flush_single_pulse", done_cnt, 1);

        // Flush while idle completes right after entry.
        clr_obs();
        flush_now = 1;
        run(3);
        chk("idle_flush_pulse", done_cnt, 1);

        // Stray response with nothing outstanding.
        inject_d = rnd512();
        inject_now = 1;
        run(1);
        chk("inject_err", resp_err, 1'b1);
        chk("inject_outstanding", outstanding, 0);
        run(10);
        chk("inject_err_sticky", resp_err, 1'b1);
        do_reset(0);
        #1;
        chk("err_cleared", resp_err, 1'b0);
        @(negedge clk); cyc_n++;

        // Reset with reads in flight: late responses flagged.
        lat_min = 15; lat_max = 15;
        add_req(0, 2);
        run(3);
        do_reset(1);
        run_until_idle(60, "midrst_timeout");
        chk("midrst_err", resp_err, 1'b1);
        chk("midrst_outstanding", outstanding, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
